// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg
//   Shared definitions for the DSP16 do/redo instruction cache.
//   Holds the controller state encoding, the cache depth, and the
//   widths and bit positions of the N (body length) and K (repeat
//   count) fields carried on do_data.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  localparam int CACHE_DEPTH = 15;
  localparam int DATA_W      = 16;
  localparam int PTR_W       = 4;

  localparam int N_W   = 4;
  localparam int N_MSB = 10;
  localparam int N_LSB = 7;

  localparam int K_W   = 7;
  localparam int K_MSB = 6;
  localparam int K_LSB = 0;

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// jtdsp16_cache_mem
//   15 x 16 register file holding the do-loop body.
//   One synchronous write port, one asynchronous (zero-cycle) read port.
//   Contents are not reset.
// Ports:
//   clk   - system clock
//   we    - write enable (already qualified by cen upstream)
//   waddr - write address, 0..14
//   wdata - word to store
//   raddr - read address, 0..14
//   rdata - word at raddr, combinational
module jtdsp16_cache_mem
  import jtdsp16_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [CACHE_DEPTH];

  // Address 15 is never produced by the controller; the guards keep the
  // 4-bit index from touching a nonexistent entry.
  always_ff @(posedge clk) begin
    if (we && (waddr < PTR_W'(CACHE_DEPTH)))
      mem[waddr] <= wdata;
  end

  assign rdata = (raddr < PTR_W'(CACHE_DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/jtdsp16_do_cache.sv
// jtdsp16_do_cache
//   do-K / redo-K loop cache controller. A do captures the next N issued
//   instruction words into the body memory and then replays them so the
//   body runs K times in total; a redo replays the stored body K times.
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   cen          - CPU clock enable; state only advances when high
//   do_start     - do-K decoded (N, K on do_data)
//   redo_start   - redo-K decoded (K on do_data)
//   do_data      - N = [10:7], K = [6:0]
//   ins_valid    - one instruction word issued this cen cycle
//   ins_in       - ROM instruction word
//   cache_dout   - replayed instruction word
//   use_cache    - decoder takes cache_dout
//   pc_halt      - hold the PC while replaying
//   no_int       - interrupts blocked while a loop is active
//   loop_end     - one-cen pulse on the last word of the final pass
//   fault        - one-cen pulse on an illegal request (request ignored)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no loop active, accepting do/redo requests
// ST_FILL   | capturing body words from ins_in into the cache
// ST_REPLAY | feeding body words from the cache, PC held
module jtdsp16_do_cache
  import jtdsp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              do_start,
  input  logic              redo_start,
  input  logic [10:0]       do_data,
  input  logic              ins_valid,
  input  logic [DATA_W-1:0] ins_in,
  output logic [DATA_W-1:0] cache_dout,
  output logic              use_cache,
  output logic              pc_halt,
  output logic              no_int,
  output logic              loop_end,
  output logic              fault
);

  state_t state, state_nx;

  logic [N_W-1:0]   n_lat;
  logic [K_W-1:0]   k_lat;
  logic [N_W-1:0]   stored_n;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [K_W-1:0]   iter;

  logic [N_W-1:0] n_in;
  logic [K_W-1:0] k_in;
  logic           do_ok, redo_ok;
  logic           fill_last, rep_last, rep_done;
  logic           mem_we;

  assign n_in = do_data[N_MSB:N_LSB];
  assign k_in = do_data[K_MSB:K_LSB];

  // A request is honoured only when it is alone, in IDLE, and has legal
  // fields; everything else is flagged through fault.
  assign do_ok   = (state == ST_IDLE) && do_start && !redo_start &&
                   (n_in != '0) && (k_in != '0);
  assign redo_ok = (state == ST_IDLE) && redo_start && !do_start &&
                   (stored_n != '0) && (k_in != '0);

  assign fill_last = (state == ST_FILL) && ins_valid &&
                     (wr_ptr == PTR_W'(n_lat - N_W'(1)));
  assign rep_last  = (state == ST_REPLAY) && ins_valid &&
                     (rd_ptr == PTR_W'(stored_n - N_W'(1)));
  assign rep_done  = rep_last && (iter == K_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else if (cen) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (do_ok) state_nx = ST_FILL;
        else if (redo_ok) state_nx = ST_REPLAY;
      end
      ST_FILL: begin
        if (fill_last) state_nx = (k_lat == K_W'(1)) ? ST_IDLE : ST_REPLAY;
      end
      ST_REPLAY: begin
        if (rep_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pulses are qualified by cen so they last exactly one CPU cycle, and
  // fault is also masked by rst so nothing is flagged while held in reset.
  always_comb begin
    use_cache = 1'b0;
    pc_halt   = 1'b0;
    no_int    = 1'b0;
    loop_end  = 1'b0;
    fault     = 1'b0;
    case (state)
      ST_FILL: begin
        no_int   = 1'b1;
        loop_end = cen && fill_last && (k_lat == K_W'(1));
      end
      ST_REPLAY: begin
        no_int    = 1'b1;
        use_cache = 1'b1;
        pc_halt   = 1'b1;
        loop_end  = cen && rep_done;
      end
      default: ;
    endcase
    fault = rst && cen && (do_start || redo_start) && !(do_ok || redo_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_lat    <= '0;
      k_lat    <= '0;
      stored_n <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      iter     <= '0;
    end else if (cen) begin
      case (state)
        ST_IDLE: begin
          if (do_ok) begin
            n_lat  <= n_in;
            k_lat  <= k_in;
            wr_ptr <= '0;
          end
          if (redo_ok) begin
            rd_ptr <= '0;
            iter   <= k_in;
          end
        end
        ST_FILL: begin
          if (ins_valid) begin
            if (fill_last) begin
              // The fill itself is the first pass, so K-1 replays remain.
              wr_ptr   <= '0;
              stored_n <= n_lat;
              rd_ptr   <= '0;
              iter     <= k_lat - K_W'(1);
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        ST_REPLAY: begin
          if (ins_valid) begin
            if (rep_last) begin
              rd_ptr <= '0;
              iter   <= iter - K_W'(1);
            end else begin
              rd_ptr <= rd_ptr + PTR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we = cen && (state == ST_FILL) && ins_valid;

  jtdsp16_cache_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (ins_in),
    .raddr (rd_ptr),
    .rdata (cache_dout)
  );

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
module tb_jtdsp16_do_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic        do_start = 1'b0;
  logic        redo_start = 1'b0;
  logic [10:0] do_data = '0;
  logic        ins_valid = 1'b0;
  logic [15:0] ins_in = '0;
  logic [15:0] cache_dout;
  logic        use_cache, pc_halt, no_int, loop_end, fault;

  int n_checks = 0;
  int n_fail = 0;
  int replay_cnt = 0;
  int le_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  jtdsp16_do_cache dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_start   (do_start),
    .redo_start (redo_start),
    .do_data    (do_data),
    .ins_valid  (ins_valid),
    .ins_in     (ins_in),
    .cache_dout (cache_dout),
    .use_cache  (use_cache),
    .pc_halt    (pc_halt),
    .no_int     (no_int),
    .loop_end   (loop_end),
    .fault      (fault)
  );

  // Scoreboard: every word the decoder consumes from the cache is popped
  // and compared against the order the bench predicted.
  always @(negedge clk) begin
    if (rst && cen && ins_valid && use_cache) begin
      n_checks++;
      replay_cnt++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL replay_extra: got %h, expected nothing", cache_dout);
      end else begin
        exp_w = exp_q.pop_front();
        if (cache_dout !== exp_w) begin
          n_fail++;
          $display("FAIL replay_word: got %h, expected %h", cache_dout, exp_w);
        end
      end
    end
    if (loop_end === 1'b1) le_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drv(input logic c, input logic d, input logic r,
                     input logic [10:0] dd, input logic v, input logic [15:0] w);
    @(posedge clk);
    #1;
    cen = c; do_start = d; redo_start = r; do_data = dd; ins_valid = v; ins_in = w;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cen = 1'b1; do_start = 1'b1; do_data = {4'd3, 7'd2};
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({use_cache, pc_halt, no_int, loop_end, fault} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {use_cache, pc_halt, no_int, loop_end, fault});
    end
    @(posedge clk);
    #1 rst = 1'b1; do_start = 1'b0;
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (no_int !== 1'b0 || use_cache !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: no_int=%b use_cache=%b, expected 0 0", no_int, use_cache);
    end
    drv(1, 0, 1, {4'd0, 7'd2}, 0, 16'h0);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_redo_fault: got %b, expected 1", fault);
    end
  endtask

  task automatic test_do_replay();
    logic [15:0] w [3];
    w[0] = 16'hA1A1; w[1] = 16'hB2B2; w[2] = 16'hC3C3;
    drv(1, 1, 0, {4'd3, 7'd2}, 0, 16'h0);
    n_checks++;
    if (fault !== 1'b0 || no_int !== 1'b0) begin
      n_fail++;
      $display("FAIL do_accept: fault=%b no_int=%b, expected 0 0", fault, no_int);
    end
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 11'd0, 1, w[i]);
      exp_q.push_back(w[i]);
      n_checks++;
      if ({no_int, use_cache, pc_halt, loop_end} !== 4'b1000) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: got %b, expected 1000", i,
                 {no_int, use_cache, pc_halt, loop_end});
      end
    end
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 11'd0, 1, 16'hDEAD);
      n_checks++;
      if ({use_cache, pc_halt, loop_end} !== {1'b1, 1'b1, (i == 2)}) begin
        n_fail++;
        $display("FAIL replay_flags[%0d]: got %b, expected %b", i,
                 {use_cache, pc_halt, loop_end}, {1'b1, 1'b1, (i == 2)});
      end
    end
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (use_cache !== 1'b0 || pc_halt !== 1'b0 || no_int !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL do_replay_end: use_cache=%b pc_halt=%b no_int=%b left=%0d, expected 0 0 0 0",
               use_cache, pc_halt, no_int, exp_q.size());
    end
  endtask

  task automatic test_k1_redo();
    drv(1, 1, 0, {4'd2, 7'd1}, 0, 16'h0);
    drv(1, 0, 0, 11'd0, 1, 16'h1234);
    n_checks++;
    if (loop_end !== 1'b0) begin
      n_fail++;
      $display("FAIL k1_first_word_le: got %b, expected 0", loop_end);
    end
    drv(1, 0, 0, 11'd0, 1, 16'h5678);
    n_checks++;
    if (loop_end !== 1'b1 || use_cache !== 1'b0) begin
      n_fail++;
      $display("FAIL k1_last_word: loop_end=%b use_cache=%b, expected 1 0", loop_end, use_cache);
    end
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (use_cache !== 1'b0 || no_int !== 1'b0) begin
      n_fail++;
      $display("FAIL k1_no_replay: use_cache=%b no_int=%b, expected 0 0", use_cache, no_int);
    end
    drv(1, 0, 1, {4'd0, 7'd3}, 0, 16'h0);
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL redo_accept: fault=%b, expected 0", fault);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 16'h1234 : 16'h5678);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        drv(1, 0, 0, 11'd0, 0, 16'h0);
        drv(0, 0, 0, 11'd0, 1, 16'h0);
        n_checks++;
        if (use_cache !== 1'b1 || loop_end !== 1'b0) begin
          n_fail++;
          $display("FAIL redo_freeze: use_cache=%b loop_end=%b, expected 1 0", use_cache, loop_end);
        end
      end
      drv(1, 0, 0, 11'd0, 1, 16'hFFFF);
      n_checks++;
      if (loop_end !== (i == 5)) begin
        n_fail++;
        $display("FAIL redo_le[%0d]: got %b, expected %b", i, loop_end, (i == 5));
      end
    end
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (use_cache !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL redo_end: use_cache=%b left=%0d, expected 0 0", use_cache, exp_q.size());
    end
  endtask

  task automatic test_faults();
    logic        fd [4];
    logic        fr [4];
    logic [10:0] fdd [4];
    fd[0] = 1; fr[0] = 0; fdd[0] = {4'd0, 7'd5};
    fd[1] = 1; fr[1] = 0; fdd[1] = {4'd4, 7'd0};
    fd[2] = 0; fr[2] = 1; fdd[2] = {4'd0, 7'd0};
    fd[3] = 1; fr[3] = 1; fdd[3] = {4'd3, 7'd3};
    for (int i = 0; i < 4; i++) begin
      drv(1, fd[i], fr[i], fdd[i], 0, 16'h0);
      n_checks++;
      if (fault !== 1'b1) begin
        n_fail++;
        $display("FAIL fault_pulse[%0d]: got %b, expected 1", i, fault);
      end
      drv(1, 0, 0, 11'd0, 0, 16'h0);
      n_checks++;
      if (fault !== 1'b0 || no_int !== 1'b0 || use_cache !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_idle[%0d]: fault=%b no_int=%b use_cache=%b, expected 0 0 0",
                 i, fault, no_int, use_cache);
      end
    end
    drv(0, 1, 0, {4'd3, 7'd2}, 0, 16'h0);
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (no_int !== 1'b0) begin
      n_fail++;
      $display("FAIL cen_low_do: no_int=%b, expected 0", no_int);
    end
  endtask

  task automatic test_overwrite();
    drv(1, 1, 0, {4'd1, 7'd3}, 0, 16'h0);
    drv(1, 0, 0, 11'd0, 1, 16'hBEEF);
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      drv(1, 0, 0, 11'd0, 1, 16'h0000);
      n_checks++;
      if (loop_end !== (i == 1) || use_cache !== 1'b1) begin
        n_fail++;
        $display("FAIL overwrite_replay[%0d]: loop_end=%b use_cache=%b, expected %b 1",
                 i, loop_end, use_cache, (i == 1));
      end
    end
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (use_cache !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overwrite_end: use_cache=%b left=%0d, expected 0 0", use_cache, exp_q.size());
    end
  endtask

  task automatic test_busy_requests();
    drv(1, 1, 0, {4'd2, 7'd2}, 0, 16'h0);
    drv(1, 0, 1, {4'd0, 7'd2}, 1, 16'h0F0F);
    exp_q.push_back(16'h0F0F);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL redo_in_fill: fault=%b, expected 1", fault);
    end
    drv(1, 0, 0, 11'd0, 1, 16'hF0F0);
    exp_q.push_back(16'hF0F0);
    drv(1, 1, 0, {4'd3, 7'd3}, 1, 16'h0);
    n_checks++;
    if (fault !== 1'b1 || use_cache !== 1'b1 || loop_end !== 1'b0) begin
      n_fail++;
      $display("FAIL do_in_replay: fault=%b use_cache=%b loop_end=%b, expected 1 1 0",
               fault, use_cache, loop_end);
    end
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    n_checks++;
    if (fault !== 1'b0 || loop_end !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_le: fault=%b loop_end=%b, expected 0 1", fault, loop_end);
    end
    drv(1, 0, 0, 11'd0, 0, 16'h0);
    n_checks++;
    if (use_cache !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL busy_end: use_cache=%b left=%0d, expected 0 0", use_cache, exp_q.size());
    end
  endtask

  task automatic test_long();
    logic [15:0] body [15];
    int fed, le0, r0;
    logic c, v;
    logic [15:0] w;
    fed = 0;
    le0 = le_cnt;
    drv(1, 1, 0, {4'd15, 7'd127}, 0, 16'h0);
    for (int cyc = 0; cyc < 2000 && fed < 15; cyc++) begin
      c = ($urandom_range(0, 3) != 0);
      v = 1'($urandom_range(0, 1));
      w = 16'($urandom);
      drv(c, 0, 0, 11'd0, v, w);
      if (c && v) begin
        body[fed] = w;
        fed++;
      end
    end
    n_checks++;
    if (fed != 15 || le_cnt != le0) begin
      n_fail++;
      $display("FAIL long_fill: fed=%0d loop_ends=%0d, expected 15 0", fed, le_cnt - le0);
    end
    for (int p = 0; p < 126; p++)
      for (int i = 0; i < 15; i++) exp_q.push_back(body[i]);
    r0 = replay_cnt;
    for (int cyc = 0; cyc < 30000 && le_cnt == le0; cyc++) begin
      c = ($urandom_range(0, 3) != 0);
      v = 1'($urandom_range(0, 1));
      drv(c, 0, 0, 11'd0, v, 16'h5A5A);
    end
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    n_checks++;
    if (le_cnt - le0 != 1 || replay_cnt - r0 != 1890 || exp_q.size() != 0 || use_cache !== 1'b0) begin
      n_fail++;
      $display("FAIL long_replay: loop_ends=%0d words=%0d left=%0d use_cache=%b, expected 1 1890 0 0",
               le_cnt - le0, replay_cnt - r0, exp_q.size(), use_cache);
    end
  endtask

  task automatic test_reset_mid();
    drv(1, 1, 0, {4'd2, 7'd3}, 0, 16'h0);
    drv(1, 0, 0, 11'd0, 1, 16'h1111);
    drv(1, 0, 0, 11'd0, 1, 16'h2222);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
    end
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    n_checks++;
    if (use_cache !== 1'b1 || pc_halt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pass2: use_cache=%b pc_halt=%b, expected 1 1", use_cache, pc_halt);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({use_cache, pc_halt, no_int, loop_end, fault} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b, expected 00000",
               {use_cache, pc_halt, no_int, loop_end, fault});
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    drv(1, 0, 1, {4'd0, 7'd2}, 0, 16'h0);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_redo_fault: got %b, expected 1", fault);
    end
    drv(1, 0, 0, 11'd0, 1, 16'h0);
    n_checks++;
    if (use_cache !== 1'b0 || no_int !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_redo_idle: use_cache=%b no_int=%b, expected 0 0", use_cache, no_int);
    end
  endtask

  initial begin
    test_reset();
    test_do_replay();
    test_k1_redo();
    test_faults();
    test_overwrite();
    test_busy_requests();
    test_long();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdsp16_do_cache.md
JTDSP16_DO_CACHE -- requirements
Module: jtdsp16_do_cache

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low; ports: clk in 1 (system clock); rst in 1 (asynchronous, active-low reset).
REQ-002 SHALL have: cen in 1 (CPU clock enable, cen2 domain; all state advances only when high).
REQ-003 SHALL have: do_start in 1 (do-K instruction decoded); redo_start in 1 (redo-K instruction decoded).
REQ-004 SHALL have: do_data in 11 (N = do_data[10:7], body length 1..15; K = do_data[6:0], repeat count 1..127).
REQ-005 SHALL have: ins_valid in 1 (one instruction word issued this cen cycle); ins_in in 16 (ROM instruction word).
REQ-006 SHALL have: cache_dout out 16 (replayed instruction word); use_cache out 1 (decoder selects cache_dout, drives up_xcache).
REQ-007 SHALL have: pc_halt out 1 (hold XAAU PC); no_int out 1 (interrupts blocked); loop_end out 1 (one-cen pulse on last word of final pass); fault out 1 (one-cen pulse, illegal request).

Function
REQ-008 SHALL implement states IDLE, FILL, REPLAY; all transitions occur only on cen=1.
REQ-009 IDLE + do_start, N>=1, K>=1: latch N, K; clear wr_ptr; enter FILL next cycle.
REQ-010 FILL: each ins_valid writes ins_in to mem[wr_ptr]; wr_ptr increments; use_cache=0, pc_halt=0.
REQ-011 FILL, write of word N-1: stored_n <= N; K=1 -> IDLE with loop_end pulse; K>1 -> REPLAY with rd_ptr=0, iter=K-1.
REQ-012 IDLE + redo_start, stored_n>=1, K>=1: REPLAY with rd_ptr=0, iter=K; body contents and stored_n unchanged.
REQ-013 REPLAY: use_cache=1, pc_halt=1; cache_dout = mem[rd_ptr] combinationally (zero-cycle read).
REQ-014 REPLAY, each ins_valid: rd_ptr increments; at rd_ptr=stored_n-1, rd_ptr wraps to 0 and iter decrements.
REQ-015 REPLAY, ins_valid with rd_ptr=stored_n-1 and iter=1: loop_end pulses same cycle; next state IDLE; pc_halt, use_cache drop next cycle.
REQ-016 no_int SHALL be 1 in FILL and REPLAY, 0 in IDLE.
REQ-017 fault pulse, request ignored, state unchanged when: N=0; K=0; redo with stored_n=0; do_start or redo_start while not IDLE; do_start and redo_start together.
REQ-018 ins_valid=0 SHALL freeze pointers and iter; cen=0 SHALL freeze all state and outputs.
REQ-019 iter 7-bit and pointers 4-bit unsigned; no wrap beyond stated limits reachable.
REQ-020 A new do_start SHALL overwrite the body from word 0; stale words above N are never read.

Reset
REQ-021 rst=0 SHALL asynchronously force IDLE; wr_ptr, rd_ptr, iter, stored_n=0; use_cache, pc_halt, no_int, loop_end, fault=0.
REQ-022 Reset mid-FILL or mid-REPLAY SHALL abort the loop; a following redo_start SHALL fault (stored_n=0).
REQ-023 Body memory contents need not be reset; cache_dout value is don't-care while use_cache=0.

Structure
REQ-024 Shared package jtdsp16_pkg SHALL hold state encoding, CACHE_DEPTH=15, N and K field widths and bit positions.
REQ-025 Body storage SHALL be sub-module jtdsp16_cache_mem: 15x16 register file, 1 sync write port, 1 async read port.
REQ-026 Controller FSM and counters SHALL reside in jtdsp16_do_cache; no other sub-modules.

Verification
REQ-027 do N=3 K=2, words A,B,C -> FILL stores A,B,C; REPLAY outputs A,B,C with pc_halt=1; loop_end on second C; IDLE.
REQ-028 do N=2 K=1, words 0x1234,0x5678 -> no REPLAY; loop_end on 0x5678 write; redo K=3 -> 6 words 0x1234,0x5678 alternating, loop_end on 6th.
REQ-029 do N=0 K=5, and do N=4 K=0 -> fault pulse each, state stays IDLE, no_int=0.
REQ-030 do N=15 K=127 with ins_valid toggling and cen gaps -> exactly 15*126 replayed words, pointer wraps at 14, loop_end once.
REQ-031 rst low during REPLAY pass 2 -> all outputs 0 immediately; subsequent redo K=2 -> fault pulse.
REQ-032 do_start asserted during REPLAY -> fault pulse; replay sequence and loop_end timing unchanged.
